// File: rtl/crossing_decision_filter.sv
// -----------------------------------------------------------------------------
// crossing_decision_filter
//
// Sequences frame captures for the zebra-crossing recogniser and filters its
// per-frame results into a stable crossing decision. Each frame is requested
// with a one-cycle capture_trigger pulse. The block then waits for
// detection_valid, or forces the frame to a miss on timeout. The frame's hit
// bit is pushed into an HISTORY_LEN-deep sliding window. crossing_confirmed
// follows the window vote with hysteresis (set at >= VOTE_THRESHOLD, clear
// below CLEAR_THRESHOLD).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enable              run the capture/vote loop
//   capturing           detector busy; holds off the trigger pulse
//   capture_trigger     one-cycle frame capture request (registered)
//   detection_valid     one-cycle per-frame result strobe
//   crossing_detected   per-frame detector decision
//   stripe_count        per-frame stripe count
//   crossing_confirmed  filtered decision
//   confirm_valid       one-cycle pulse when the filter outputs update
//   vote_count          hits currently in the window
//   frames_evaluated    frames processed, saturating
//   timeout_error       sticky, set when any frame times out
//
// Optional feature, macro CROSSING_STATS_EN:
//   hit_frames          saturating count of hit frames
//   max_stripes         largest stripe_count accepted on a detection_valid
// -----------------------------------------------------------------------------
module crossing_decision_filter #(
  parameter int HISTORY_LEN      = 8,
  parameter int VOTE_THRESHOLD   = 5,
  parameter int CLEAR_THRESHOLD  = 3,
  parameter int MIN_STRIPES      = 4,
  parameter int TRIGGER_INTERVAL = 1000000,
  parameter int TIMEOUT_CYCLES   = 4000000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic                               capturing,
  output logic                               capture_trigger,
  input  logic                               detection_valid,
  input  logic                               crossing_detected,
  input  logic [7:0]                         stripe_count,
  output logic                               crossing_confirmed,
  output logic                               confirm_valid,
  output logic [$clog2(HISTORY_LEN+1)-1:0]   vote_count,
  output logic [15:0]                        frames_evaluated,
  output logic                               timeout_error
`ifdef CROSSING_STATS_EN
  ,
  output logic [15:0]                        hit_frames,
  output logic [7:0]                         max_stripes
`endif
);

  localparam int VW = $clog2(HISTORY_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = $clog2(TRIGGER_INTERVAL + 1);

  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE     = TW'(1);
  localparam logic [IW-1:0] IV_LAST    = IW'(TRIGGER_INTERVAL - 1);
  localparam logic [IW-1:0] IV_ONE     = IW'(1);
  localparam logic [VW-1:0] VOTE_SET   = VW'(VOTE_THRESHOLD);
  localparam logic [VW-1:0] VOTE_CLR   = VW'(CLEAR_THRESHOLD);
  localparam logic [7:0]    STRIPE_MIN = 8'(MIN_STRIPES);

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    TRIGGER       = 3'd1,
    WAIT_RESULT   = 3'd2,
    UPDATE        = 3'd3,
    WAIT_INTERVAL = 3'd4
  } state_t;

  state_t                 state_r;
  logic [HISTORY_LEN-1:0] history_r;
  logic [TW-1:0]          timeout_cnt_r;
  logic [IW-1:0]          interval_cnt_r;
  logic                   hit_r;

  logic                   frame_hit_s;
  logic [VW-1:0]          vote_next_s;
  logic                   confirm_next_s;

`ifdef CROSSING_STATS_EN
  logic [7:0]             stripe_r;
  logic                   stripe_seen_r;
`endif

  // Hit qualification of the incoming result and the vote/hysteresis outcome of the pending UPDATE
  always_comb begin
    frame_hit_s = crossing_detected && (stripe_count >= STRIPE_MIN);
    // Oldest bit leaves as the new hit enters; it is 0 until the window has filled.
    vote_next_s = vote_count + VW'(hit_r) - VW'(history_r[HISTORY_LEN-1]);
    if (vote_next_s >= VOTE_SET) begin
      confirm_next_s = 1'b1;
    end else if (vote_next_s < VOTE_CLR) begin
      confirm_next_s = 1'b0;
    end else begin
      confirm_next_s = crossing_confirmed;
    end
  end

  // Capture/vote sequencer: state, counters, history window and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r            <= IDLE;
      history_r          <= '0;
      timeout_cnt_r      <= '0;
      interval_cnt_r     <= '0;
      hit_r              <= 1'b0;
      capture_trigger    <= 1'b0;
      crossing_confirmed <= 1'b0;
      confirm_valid      <= 1'b0;
      vote_count         <= '0;
      frames_evaluated   <= 16'd0;
      timeout_error      <= 1'b0;
`ifdef CROSSING_STATS_EN
      stripe_r           <= 8'd0;
      stripe_seen_r      <= 1'b0;
      hit_frames         <= 16'd0;
      max_stripes        <= 8'd0;
`endif
    end else begin
      capture_trigger <= 1'b0;
      confirm_valid   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (enable) begin
            state_r <= TRIGGER;
          end
        end
        TRIGGER: begin
          // Retry every cycle until the detector is free.
          if (!capturing) begin
            capture_trigger <= 1'b1;
            timeout_cnt_r   <= '0;
            state_r         <= WAIT_RESULT;
          end
        end
        WAIT_RESULT: begin
          timeout_cnt_r <= timeout_cnt_r + TO_ONE;
          // A result arriving in the timeout cycle takes priority over the timeout.
          if (detection_valid) begin
            hit_r   <= frame_hit_s;
            state_r <= UPDATE;
`ifdef CROSSING_STATS_EN
            stripe_r      <= stripe_count;
            stripe_seen_r <= 1'b1;
`endif
          end else if (timeout_cnt_r == TO_LAST) begin
            hit_r         <= 1'b0;
            timeout_error <= 1'b1;
            state_r       <= UPDATE;
`ifdef CROSSING_STATS_EN
            stripe_seen_r <= 1'b0;
`endif
          end
        end
        UPDATE: begin
          history_r          <= {history_r[HISTORY_LEN-2:0], hit_r};
          vote_count         <= vote_next_s;
          crossing_confirmed <= confirm_next_s;
          confirm_valid      <= 1'b1;
          if (frames_evaluated != 16'hFFFF) begin
            frames_evaluated <= frames_evaluated + 16'd1;
          end
`ifdef CROSSING_STATS_EN
          if (hit_r && (hit_frames != 16'hFFFF)) begin
            hit_frames <= hit_frames + 16'd1;
          end
          if (stripe_seen_r && (stripe_r > max_stripes)) begin
            max_stripes <= stripe_r;
          end
`endif
          interval_cnt_r <= '0;
          state_r        <= enable ? WAIT_INTERVAL : IDLE;
        end
        WAIT_INTERVAL: begin
          if (!enable) begin
            interval_cnt_r <= '0;
            state_r        <= IDLE;
          end else if (interval_cnt_r == IV_LAST) begin
            interval_cnt_r <= '0;
            state_r        <= TRIGGER;
          end else begin
            interval_cnt_r <= interval_cnt_r + IV_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crossing_decision_filter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for crossing_decision_filter.
// Table-driven frame vectors with hand-derived expectations, hand-written
// corner sequences (trigger timing, timeout, reset mid-frame, busy detector,
// disable mid-frame) and randomized frames checked against a window model.
// -----------------------------------------------------------------------------
module tb_crossing_decision_filter;

  localparam int HL  = 4;
  localparam int VT  = 3;
  localparam int CT  = 2;
  localparam int MS  = 4;
  localparam int TI  = 20;
  localparam int TO  = 50;
  localparam int VW  = $clog2(HL + 1);

  logic          clk;
  logic          rst;
  logic          enable;
  logic          capturing;
  logic          capture_trigger;
  logic          detection_valid;
  logic          crossing_detected;
  logic [7:0]    stripe_count;
  logic          crossing_confirmed;
  logic          confirm_valid;
  logic [VW-1:0] vote_count;
  logic [15:0]   frames_evaluated;
  logic          timeout_error;
`ifdef CROSSING_STATS_EN
  logic [15:0]   hit_frames;
  logic [7:0]    max_stripes;
`endif

  crossing_decision_filter #(
    .HISTORY_LEN     (HL),
    .VOTE_THRESHOLD  (VT),
    .CLEAR_THRESHOLD (CT),
    .MIN_STRIPES     (MS),
    .TRIGGER_INTERVAL(TI),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .capturing         (capturing),
    .capture_trigger   (capture_trigger),
    .detection_valid   (detection_valid),
    .crossing_detected (crossing_detected),
    .stripe_count      (stripe_count),
    .crossing_confirmed(crossing_confirmed),
    .confirm_valid     (confirm_valid),
    .vote_count        (vote_count),
    .frames_evaluated  (frames_evaluated),
    .timeout_error     (timeout_error)
`ifdef CROSSING_STATS_EN
    ,
    .hit_frames        (hit_frames),
    .max_stripes       (max_stripes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: last HL frame outcomes kept as a queue, vote = popcount.
  bit win[$];
  int m_vote;
  bit m_conf;
  int m_frames;
  bit m_terr;
  int m_hits;
  int m_max;

  function void model_reset();
    win.delete();
    m_vote = 0; m_conf = 1'b0; m_frames = 0; m_terr = 1'b0; m_hits = 0; m_max = 0;
  endfunction

  function void model_frame(input bit hit, input bit tmo, input int sc);
    win.push_back(hit);
    if (win.size() > HL) void'(win.pop_front());
    m_vote = 0;
    foreach (win[i]) m_vote += int'(win[i]);
    if (m_vote >= VT) m_conf = 1'b1;
    else if (m_vote < CT) m_conf = 1'b0;
    if (m_frames < 65535) m_frames++;
    if (tmo) m_terr = 1'b1;
    if (hit && m_hits < 65535) m_hits++;
    if (!tmo && sc > m_max) m_max = sc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_trigger(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (capture_trigger === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_trigger: no capture_trigger within %0d cycles", limit);
    end
  endtask

  // Called in the confirm_valid cycle. Issues a stray result (must be ignored),
  // holds capturing high for k cycles, then expects the next trigger pulse.
  task automatic next_trigger(input int k, input string tag);
    int n;
    int n_exp;
    detection_valid = 1'b1; crossing_detected = 1'b1; stripe_count = 8'd200;
    tick();
    detection_valid = 1'b0; crossing_detected = 1'b0; stripe_count = 8'd0;
    capturing = (k > 0);
    for (int i = 0; i < k; i++) begin
      tick();
      check({tag, " busy_hold"}, capture_trigger, 0);
    end
    capturing = 1'b0;
    wait_trigger(100, n);
    // TRIGGER is entered TI cycles after the confirm cycle; the pulse follows one cycle later.
    n_exp = (k >= TI - 1) ? 1 : TI - k;
    check({tag, " trig_gap"}, n, n_exp);
  endtask

  // Called in the cycle the trigger pulse is visible (first result-wait cycle).
  // dly >= TO means the detector never answers.
  task automatic run_frame(input bit cd, input logic [7:0] sc, input int dly, input string tag);
    bit hit;
    bit tmo;
    if (dly >= TO) begin
      for (int i = 0; i < TO; i++) begin
        tick();
        if (i == 0) check({tag, " single_pulse"}, capture_trigger, 0);
      end
      hit = 1'b0;
      tmo = 1'b1;
    end else begin
      for (int i = 0; i < dly; i++) begin
        tick();
        if (i == 0) check({tag, " single_pulse"}, capture_trigger, 0);
      end
      detection_valid = 1'b1; crossing_detected = cd; stripe_count = sc;
      tick();
      detection_valid = 1'b0; crossing_detected = 1'b0; stripe_count = 8'd0;
      hit = cd && (int'(sc) >= MS);
      tmo = 1'b0;
    end
    check({tag, " cv_early"}, confirm_valid, 0);
    tick();
    model_frame(hit, tmo, int'(sc));
    check({tag, " cv"}, confirm_valid, 1);
    check({tag, " vote"}, vote_count, m_vote);
    check({tag, " confirmed"}, crossing_confirmed, m_conf);
    check({tag, " frames"}, frames_evaluated, m_frames);
    check({tag, " timeout_error"}, timeout_error, m_terr);
`ifdef CROSSING_STATS_EN
    check({tag, " hit_frames"}, hit_frames, m_hits);
    check({tag, " max_stripes"}, max_stripes, m_max);
`endif
  endtask

  typedef struct {
    bit         cd;
    logic [7:0] sc;
    int         dly;
    int         exp_vote;
    bit         exp_conf;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int idle_pulses;

    tbl[0]  = '{1'b1, 8'd3,   5, 0, 1'b0};
    tbl[1]  = '{1'b0, 8'd9,   1, 0, 1'b0};
    tbl[2]  = '{1'b1, 8'd4,   0, 1, 1'b0};
    tbl[3]  = '{1'b1, 8'd5,   2, 2, 1'b0};
    tbl[4]  = '{1'b1, 8'd255, 7, 3, 1'b1};
    tbl[5]  = '{1'b1, 8'd5,   3, 4, 1'b1};
    tbl[6]  = '{1'b1, 8'd6,   1, 4, 1'b1};
    tbl[7]  = '{1'b0, 8'd5,   2, 3, 1'b1};
    tbl[8]  = '{1'b1, 8'd0,   4, 2, 1'b1};
    tbl[9]  = '{1'b0, 8'd0,   0, 1, 1'b0};
    tbl[10] = '{1'b1, 8'd2,   6, 0, 1'b0};
    tbl[11] = '{1'b0, 8'd8,   1, 0, 1'b0};
    tbl[12] = '{1'b1, 8'd5,   2, 1, 1'b0};
    tbl[13] = '{1'b1, 8'd9,   0, 2, 1'b0};
    tbl[14] = '{1'b1, 8'd4,   3, 3, 1'b1};

    rst = 1'b1; enable = 1'b0; capturing = 1'b0;
    detection_valid = 1'b0; crossing_detected = 1'b0; stripe_count = 8'd0;
    model_reset();

    // Reset state and trigger timing
    tick();
    tick();
    check("rst trigger", capture_trigger, 0);
    check("rst confirmed", crossing_confirmed, 0);
    check("rst cv", confirm_valid, 0);
    check("rst vote", vote_count, 0);
    check("rst frames", frames_evaluated, 0);
    check("rst timeout_error", timeout_error, 0);
    rst = 1'b0; enable = 1'b1;
    tick();
    check("t1 trig_early", capture_trigger, 0);
    tick();
    check("t1 trig_at2", capture_trigger, 1);

    // Table-driven frames: gating, vote build-up, window saturation, hysteresis
    for (int i = 0; i < 15; i++) begin
      if (i > 0) next_trigger(0, "tbl");
      run_frame(tbl[i].cd, tbl[i].sc, tbl[i].dly, "tbl");
      check("tbl exp_vote", vote_count, tbl[i].exp_vote);
      check("tbl exp_conf", crossing_confirmed, tbl[i].exp_conf);
      check("tbl exp_frames", frames_evaluated, i + 1);
    end

    // Detector stall: frame forced to a miss, flag sticky across the next normal frame
    next_trigger(0, "tmo");
    run_frame(1'b1, 8'd5, TO, "tmo");
    check("tmo flag", timeout_error, 1);
    next_trigger(0, "sticky");
    run_frame(1'b1, 8'd5, 2, "sticky");
    check("sticky flag", timeout_error, 1);

    // Reset mid-frame with enable held: everything clears, loop restarts
    next_trigger(0, "pre_rst");
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("mid_rst trigger", capture_trigger, 0);
    check("mid_rst timeout_error", timeout_error, 0);
    check("mid_rst vote", vote_count, 0);
    check("mid_rst frames", frames_evaluated, 0);
    tick();
    check("mid_rst trigger2", capture_trigger, 0);
    rst = 1'b0;
    model_reset();
    tick();
    check("post_rst trig_early", capture_trigger, 0);
    tick();
    check("post_rst trig_at2", capture_trigger, 1);

    // Result arriving in the timeout cycle wins
    run_frame(1'b1, 8'd6, TO - 1, "tmo_edge");
    check("tmo_edge flag", timeout_error, 0);
    check("tmo_edge vote", vote_count, 1);

    // Randomized frames against the window model
    for (int r = 0; r < 30; r++) begin
      int         sel;
      int         k;
      int         dly;
      bit         cd;
      logic [7:0] sc;
      sel = $urandom_range(0, 9);
      if (sel == 0)      dly = TO;
      else if (sel == 1) dly = TO - 1;
      else               dly = $urandom_range(0, 12);
      cd = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) sc = 8'($urandom_range(0, 255));
      else                           sc = 8'($urandom_range(0, 8));
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
      next_trigger(k, "rnd");
      run_frame(cd, sc, dly, "rnd");
    end

    // Busy detector: capturing high for 10 cycles while in TRIGGER
    next_trigger(TI - 1 + 10, "busy10");
    run_frame(1'b1, 8'd5, 1, "busy10");

    // Disable during result wait: frame still completes, then no more triggers
    next_trigger(0, "dis");
    enable = 1'b0;
    run_frame(1'b1, 8'd7, 3, "dis");
    idle_pulses = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (capture_trigger === 1'b1) idle_pulses++;
    end
    check("dis no_trigger", idle_pulses, 0);
    check("dis vote_hold", vote_count, m_vote);
    check("dis frames_hold", frames_evaluated, m_frames);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
